core_mem_bridge: RTL

Bus bridge between the rv32e core's memory port and the on-chip memory/peripheral fabric. It decodes each core access, stalls the core until the access completes, and runs a req/ack handshake toward memory. It aligns and sign- or zero-extends read data, rejects misaligned accesses, and bounds every memory access with a timeout.

---
 rtl/core_mem_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/core_mem_bridge.sv
// Bridge between the rv32e core memory port and the req/ack memory fabric.
// Optional local extio register enabled by defining CORE_MEM_BRIDGE_EXTIO_EN.
module core_mem_bridge #(
   parameter int          MEMORY_BUS_WIDTH = 32,
   parameter int          TIMEOUT_CYCLES   = 255,
   parameter logic [31:0] EXTIO_ADDR       = 32'hFFFF_FF00
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [MEMORY_BUS_WIDTH-1:0] cpu_addr_in,
   input  logic [MEMORY_BUS_WIDTH-1:0] cpu_data_in,
   input  logic [3:0]                  cpu_wb_in,
   input  logic [2:0]                  cpu_data_mode_in,
   output logic [MEMORY_BUS_WIDTH-1:0] cpu_data_out,
   output logic                        cpu_stall_out,
   output logic                        mem_req_out,
   output logic [MEMORY_BUS_WIDTH-1:0] mem_addr_out,
   output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata_out,
   output logic [3:0]                  mem_wstrb_out,
   input  logic                        mem_ack_in,
   input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata_in,
   input  logic [7:0]                  extio_in,
   output logic [7:0]                  extio_out,
   output logic                        err_out,
   output logic [1:0]                  state_dbg
);

   localparam int W = MEMORY_BUS_WIDTH;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   // Handshake: mem_req_out rises with mem_addr/wdata/wstrb already valid and
   // holds them stable until the single-cycle mem_ack_in pulse or a timeout.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [1:0]  lat_off;
   logic [2:0]  lat_mode;
   logic        lat_read;
   logic        pending;
   logic        misaligned;
   logic        local_hit;
   logic        is_read;

   assign pending    = cpu_data_mode_in[1:0] != 2'b00;
   assign is_read    = cpu_wb_in == 4'b0000;
   assign misaligned = ((cpu_data_mode_in[1:0] == 2'b10) && cpu_addr_in[0]) ||
                       ((cpu_data_mode_in[1:0] == 2'b11) && (cpu_addr_in[1:0] != 2'b00));
   assign cpu_stall_out = pending && (state != DONE);
   assign state_dbg     = state;

   function automatic logic [W-1:0] align_read(input logic [W-1:0] rd,
                                               input logic [1:0]   off,
                                               input logic [2:0]   mode);
      logic [W-1:0] sh;
      logic [W-1:0] res;
      sh  = '0;
      res = rd;
      case (mode[1:0])
         2'b01: begin
            sh  = rd >> {off, 3'b000};
            res = mode[2] ? {{(W-8){1'b0}}, sh[7:0]} : {{(W-8){sh[7]}}, sh[7:0]};
         end
         2'b10: begin
            sh  = rd >> {off[1], 4'b0000};
            res = mode[2] ? {{(W-16){1'b0}}, sh[15:0]} : {{(W-16){sh[15]}}, sh[15:0]};
         end
         default: res = rd;
      endcase
      return res;
   endfunction

`ifdef CORE_MEM_BRIDGE_EXTIO_EN
   logic [7:0] extio_meta;
   logic [7:0] extio_sync;

   assign local_hit = (cpu_data_mode_in[1:0] == 2'b11) && (cpu_addr_in == EXTIO_ADDR);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         extio_meta <= '0;
         extio_sync <= '0;
      end else begin
         extio_meta <= extio_in;
         extio_sync <= extio_meta;
      end
   end
`else
   logic unused_extio;

   assign local_hit    = 1'b0;
   assign extio_out    = '0;
   assign unused_extio = ^extio_in ^ ^EXTIO_ADDR;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_off       <= '0;
         lat_mode      <= '0;
         lat_read      <= 1'b0;
         cpu_data_out  <= '0;
         mem_req_out   <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         mem_wstrb_out <= '0;
         err_out       <= 1'b0;
`ifdef CORE_MEM_BRIDGE_EXTIO_EN
         extio_out     <= '0;
`endif
      end else begin
         err_out <= 1'b0;
         case (state)
            IDLE: begin
               if (pending) begin
                  lat_off  <= cpu_addr_in[1:0];
                  lat_mode <= cpu_data_mode_in;
                  lat_read <= is_read;
                  if (misaligned) begin
                     err_out <= 1'b1;
                     if (is_read) cpu_data_out <= '0;
                     state <= DONE;
                  end else if (local_hit) begin
`ifdef CORE_MEM_BRIDGE_EXTIO_EN
                     if (is_read) cpu_data_out <= {{(W-8){1'b0}}, extio_sync};
                     else if (cpu_wb_in[0]) extio_out <= cpu_data_in[7:0];
`endif
                     state <= DONE;
                  end else begin
                     mem_req_out   <= 1'b1;
                     mem_addr_out  <= {cpu_addr_in[W-1:2], 2'b00};
                     mem_wdata_out <= cpu_data_in;
                     mem_wstrb_out <= cpu_wb_in;
                     cnt           <= '0;
                     state         <= REQ;
                  end
               end
            end
            REQ: begin
               // An ack in the final allowed cycle still completes normally.
               if (mem_ack_in) begin
                  mem_req_out <= 1'b0;
                  if (lat_read) cpu_data_out <= align_read(mem_rdata_in, lat_off, lat_mode);
                  state <= DONE;
               end else if (cnt == TO_LAST) begin
                  mem_req_out <= 1'b0;
                  err_out     <= 1'b1;
                  if (lat_read) cpu_data_out <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
